// File: rtl/timer_sampler.sv
// Coherent 96-bit timestamp reader: reads seconds lo/hi and nanoseconds from the timer,
// re-reads seconds lo to detect a seconds carry mid-sequence, and retries on mismatch.
module timer_sampler #(
   parameter int unsigned MAX_RETRIES    = 3,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req,
   output logic        o_busy,
   output logic        o_valid,
   output logic        o_err,
   output logic [63:0] o_seconds,
   output logic [31:0] o_nanoseconds,
   output logic [3:0]  o_addr,
   output logic        o_stb,
   input  logic [31:0] i_dat_r,
   input  logic        i_ack
);

   localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam int unsigned TmoW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);
   localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

   state_e            state_q, state_d;
   logic [1:0]        step_q, step_d;
   logic [RetryW-1:0] retry_q, retry_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic [31:0]       lo1_q, lo1_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       ns_q, ns_d;
   logic              done_ok, done_err;

   logic              busy_d, valid_d, err_d, stb_d;
   logic [3:0]        addr_d;
   logic [63:0]       seconds_d;
   logic [31:0]       nanoseconds_d;

   // State and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= StIdle;
         step_q        <= 2'd0;
         retry_q       <= '0;
         tmo_q         <= '0;
         lo1_q         <= 32'd0;
         hi_q          <= 32'd0;
         ns_q          <= 32'd0;
         o_busy        <= 1'b0;
         o_valid       <= 1'b0;
         o_err         <= 1'b0;
         o_stb         <= 1'b0;
         o_addr        <= 4'h0;
         o_seconds     <= 64'd0;
         o_nanoseconds <= 32'd0;
      end else begin
         state_q       <= state_d;
         step_q        <= step_d;
         retry_q       <= retry_d;
         tmo_q         <= tmo_d;
         lo1_q         <= lo1_d;
         hi_q          <= hi_d;
         ns_q          <= ns_d;
         o_busy        <= busy_d;
         o_valid       <= valid_d;
         o_err         <= err_d;
         o_stb         <= stb_d;
         o_addr        <= addr_d;
         o_seconds     <= seconds_d;
         o_nanoseconds <= nanoseconds_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      retry_d  = retry_q;
      tmo_d    = tmo_q;
      lo1_d    = lo1_q;
      hi_d     = hi_q;
      ns_d     = ns_q;
      done_ok  = 1'b0;
      done_err = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (i_req) begin
               state_d = StReq;
               step_d  = 2'd0;
               retry_d = '0;
               tmo_d   = '0;
            end
         end
         StReq: begin
            // An ack on the final timeout edge still completes the read.
            if (i_ack) begin
               tmo_d = '0;
               unique case (step_q)
                  2'd0: begin
                     lo1_d   = i_dat_r;
                     step_d  = 2'd1;
                     state_d = StGap;
                  end
                  2'd1: begin
                     hi_d    = i_dat_r;
                     step_d  = 2'd2;
                     state_d = StGap;
                  end
                  2'd2: begin
                     ns_d    = i_dat_r;
                     step_d  = 2'd3;
                     state_d = StGap;
                  end
                  2'd3: begin
                     if (i_dat_r == lo1_q) begin
                        done_ok = 1'b1;
                        state_d = StIdle;
                     end else if (retry_q < RetryMax) begin
                        retry_d = retry_q + 1'b1;
                        step_d  = 2'd0;
                        state_d = StGap;
                     end else begin
                        done_err = 1'b1;
                        state_d  = StIdle;
                     end
                  end
               endcase
            end else if (tmo_q == TmoLast) begin
               done_err = 1'b1;
               state_d  = StIdle;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StGap: begin
            state_d = StReq;
            tmo_d   = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   // Output next values, registered above
   always_comb begin
      stb_d         = (state_d == StReq);
      busy_d        = (state_d != StIdle);
      valid_d       = done_ok;
      err_d         = done_err;
      addr_d        = o_addr;
      seconds_d     = o_seconds;
      nanoseconds_d = o_nanoseconds;
      if (stb_d) begin
         unique case (step_d)
            2'd0:    addr_d = 4'h0;
            2'd1:    addr_d = 4'h4;
            2'd2:    addr_d = 4'h8;
            2'd3:    addr_d = 4'h0;
         endcase
      end
      if (done_ok) begin
         seconds_d     = {hi_q, lo1_q};
         nanoseconds_d = ns_q;
      end
   end

endmodule

// File: tb/tb_timer_sampler.sv
// Directed bench for timer_sampler: table of whole operations against a model responder,
// plus hand sequences for busy-ignore, back-to-back requests and reset mid-operation.
module tb_timer_sampler;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_req;
   logic        o_busy;
   logic        o_valid;
   logic        o_err;
   logic [63:0] o_seconds;
   logic [31:0] o_nanoseconds;
   logic [3:0]  o_addr;
   logic        o_stb;
   logic [31:0] i_dat_r = 32'd0;
   logic        i_ack = 1'b0;

   timer_sampler #(
      .MAX_RETRIES   (3),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_req        (i_req),
      .o_busy       (o_busy),
      .o_valid      (o_valid),
      .o_err        (o_err),
      .o_seconds    (o_seconds),
      .o_nanoseconds(o_nanoseconds),
      .o_addr       (o_addr),
      .o_stb        (o_stb),
      .i_dat_r      (i_dat_r),
      .i_ack        (i_ack)
   );

   always #5 i_clk = ~i_clk;

   int errors = 0;
   int checks = 0;
   int edges  = 0;

   always @(posedge i_clk) edges <= edges + 1;

   // Responder: 0 = stable sec 0x1_FFFFFFF0 ns 123, 1 = seconds carry on first LO2,
   // 2 = LO changes on every read, 4 = never acks.
   int pattern = 0;
   int waits   = 0;
   int rd_idx  = 0;
   int wcnt    = 0;

   function automatic logic [31:0] resp(input int pat, input int idx, input logic [3:0] addr);
      case (pat)
         1: begin
            if (idx == 0) return 32'hFFFF_FFFF;
            case (addr)
               4'h0:    return 32'h0000_0000;
               4'h4:    return 32'd2;
               default: return 32'd77;
            endcase
         end
         2: begin
            case (addr)
               4'h0:    return 32'(idx);
               4'h4:    return 32'd5;
               default: return 32'd9;
            endcase
         end
         default: begin
            case (addr)
               4'h0:    return 32'hFFFF_FFF0;
               4'h4:    return 32'd1;
               default: return 32'd123;
            endcase
         end
      endcase
   endfunction

   always @(negedge i_clk) begin
      if (!o_busy || i_rst) begin
         rd_idx = 0;
         wcnt   = 0;
         i_ack  = 1'b0;
      end else if (o_stb && pattern != 4) begin
         if (wcnt < waits) begin
            wcnt++;
            i_ack = 1'b0;
         end else begin
            i_ack   = 1'b1;
            i_dat_r = resp(pattern, rd_idx, o_addr);
            rd_idx++;
            wcnt = 0;
         end
      end else begin
         i_ack = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] addr_of(input int n);
      case (n % 4)
         1:       return 4'h4;
         2:       return 4'h8;
         default: return 4'h0;
      endcase
   endfunction

   // Results of the last run_op
   int r_first, r_last, r_nstb, r_valid, r_err, r_addr_err, r_both, e0;

   // Issue one request and watch until o_valid/o_err; req_at raises i_req for one cycle.
   task automatic run_op(input int req_at);
      int c;
      int nacks;
      bit done;
      r_first = 0; r_last = 0; r_nstb = 0; r_valid = 0; r_err = 0;
      r_addr_err = 0; r_both = 0; nacks = 0; done = 1'b0;
      @(negedge i_clk);
      i_req = 1'b1;
      e0    = edges;
      @(posedge i_clk);
      #1 i_req = 1'b0;
      for (int it = 0; it < 60 && !done; it++) begin
         @(negedge i_clk);
         #1;
         c = edges - e0;
         i_req = (c == req_at);
         if (o_stb) begin
            r_nstb++;
            if (r_first == 0) r_first = c;
            r_last = c;
            if (o_addr !== addr_of(nacks)) r_addr_err++;
            if (i_ack) nacks++;
         end
         if (o_valid && o_err) r_both++;
         if (o_valid) begin
            r_valid = c;
            done    = 1'b1;
         end
         if (o_err) begin
            r_err = c;
            done  = 1'b1;
         end
      end
      if (!done) begin
         errors++;
         checks++;
         $display("FAIL op_bound: got no o_valid/o_err within 60 cycles, required a pulse");
      end
   endtask

   typedef struct {
      string       name;
      int          pat;
      int          waits;
      int          nstb;
      int          last_stb;
      int          valid_cyc;
      int          err_cyc;
      logic [63:0] sec;
      logic [31:0] ns;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int c;
      int pulses;
      bit seen;

      vecs[0] = '{"zero_wait", 0, 0,  4,  7,  8,  0, 64'h0000_0001_FFFF_FFF0, 32'd123};
      vecs[1] = '{"rollover",  1, 0,  8, 15, 16,  0, 64'h0000_0002_0000_0000, 32'd77};
      vecs[2] = '{"exhaust",   2, 0, 16, 31,  0, 32, 64'h0000_0002_0000_0000, 32'd77};
      vecs[3] = '{"wait3",     0, 3, 16, 19, 20,  0, 64'h0000_0001_FFFF_FFF0, 32'd123};
      vecs[4] = '{"timeout",   4, 0, 16, 16,  0, 17, 64'h0000_0001_FFFF_FFF0, 32'd123};
      vecs[5] = '{"after_to",  1, 0,  8, 15, 16,  0, 64'h0000_0002_0000_0000, 32'd77};

      i_rst = 1'b1;
      i_req = 1'b0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      #1;
      chk("rst_busy",  64'(o_busy),  64'd0);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_err",   64'(o_err),   64'd0);
      chk("rst_stb",   64'(o_stb),   64'd0);
      chk("rst_addr",  64'(o_addr),  64'd0);
      chk("rst_sec",   o_seconds,    64'd0);
      chk("rst_ns",    64'(o_nanoseconds), 64'd0);
      i_rst = 1'b0;

      for (int v = 0; v < 6; v++) begin
         pattern = vecs[v].pat;
         waits   = vecs[v].waits;
         run_op(-1);
         chk({vecs[v].name, "_first_stb"}, 64'(r_first),    64'd1);
         chk({vecs[v].name, "_last_stb"},  64'(r_last),     64'(vecs[v].last_stb));
         chk({vecs[v].name, "_nstb"},      64'(r_nstb),     64'(vecs[v].nstb));
         chk({vecs[v].name, "_addr_seq"},  64'(r_addr_err), 64'd0);
         chk({vecs[v].name, "_valid_cyc"}, 64'(r_valid),    64'(vecs[v].valid_cyc));
         chk({vecs[v].name, "_err_cyc"},   64'(r_err),      64'(vecs[v].err_cyc));
         chk({vecs[v].name, "_both"},      64'(r_both),     64'd0);
         chk({vecs[v].name, "_busy_end"},  64'(o_busy),     64'd0);
         chk({vecs[v].name, "_sec"},       o_seconds,       vecs[v].sec);
         chk({vecs[v].name, "_ns"},        64'(o_nanoseconds), 64'(vecs[v].ns));
      end

      // Request while busy is dropped, not queued
      pattern = 0;
      waits   = 0;
      run_op(3);
      chk("busy_req_valid_cyc", 64'(r_valid), 64'd8);
      @(negedge i_clk);
      #1;
      i_req = 1'b0;
      chk("busy_req_no_stb",  64'(o_stb),  64'd0);
      chk("busy_req_no_busy", 64'(o_busy), 64'd0);

      // Request in the o_valid cycle starts a new operation at once
      run_op(8);
      chk("b2b_valid_cyc", 64'(r_valid), 64'd8);
      @(negedge i_clk);
      #1;
      i_req = 1'b0;
      chk("b2b_stb",  64'(o_stb),  64'd1);
      chk("b2b_addr", 64'(o_addr), 64'd0);
      seen = 1'b0;
      c    = 0;
      for (int it = 0; it < 30 && !seen; it++) begin
         @(negedge i_clk);
         #1;
         if (o_valid) begin
            seen = 1'b1;
            c    = edges - e0;
         end
      end
      chk("b2b_second_valid_cyc", 64'(c), 64'd16);

      // Reset mid-operation: sampled at edge 4, strobe gone in cycle 5, no pulses
      @(negedge i_clk);
      i_req = 1'b1;
      e0    = edges;
      @(posedge i_clk);
      #1 i_req = 1'b0;
      pulses = 0;
      for (int it = 0; it < 12; it++) begin
         @(negedge i_clk);
         #1;
         c = edges - e0;
         if (c == 4) i_rst = 1'b1;
         if (c == 5) begin
            chk("rst_mid_stb",  64'(o_stb),  64'd0);
            chk("rst_mid_busy", 64'(o_busy), 64'd0);
         end
         if (c >= 5 && (o_valid || o_err)) pulses++;
      end
      chk("rst_mid_pulses", 64'(pulses), 64'd0);
      chk("rst_mid_sec",    o_seconds,   64'd0);
      i_rst = 1'b0;
      repeat (2) @(negedge i_clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by 200000, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
